decoder_scan_sequencer: RTL

Upstream driver and downstream collector for the 3-to-8 enabled decoder block (inputs w0/w1/w2/en, output f). On a start request it walks the select code 0..7 with the decoder enabled and waits a programmable settle time per code. It samples f for each code into an 8-bit truth mask, then reports completion. It converts the combinational decoder into a self-checking, handshaked function evaluator.

---
 rtl/decoder_scan_sequencer.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/decoder_scan_sequencer.sv
// ---------------------------------------------------------------------------
// decoder_scan_sequencer
//
// Drives the select code 0..7 into a 3-to-8 enabled decoder and collects its
// output f into an 8-bit truth mask. A start request in IDLE launches a scan.
// Each code is held for SETTLE_CYCLES cycles, then sampled for one cycle.
// After code 7 is sampled, done pulses for one cycle.
//
// Optional feature macro: SCAN_ABORT_EN
//   When defined, an abort input is added. An abort seen in SETTLE or SAMPLE
//   returns the block to IDLE with the result cleared and no done pulse.
//   Abort takes priority over the SAMPLE update in the same cycle.
//   When the macro is undefined, a scan always runs to completion unless rst
//   is asserted.
//
// All outputs come straight from flops, so no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module decoder_scan_sequencer #(
    parameter int SETTLE_CYCLES = 1,   // cycles each code is held before sampling (>= 1)
    parameter int NUM_CODES     = 8    // fixed by the 3-bit decoder select
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
`ifdef SCAN_ABORT_EN
    input  logic       abort,
`endif
    input  logic       f,
    output logic       w0,
    output logic       w1,
    output logic       w2,
    output logic       en,
    output logic       busy,
    output logic       done,
    output logic [7:0] result
);

    // The settle counter only ever reaches SETTLE_CYCLES-1.
    localparam int              CNT_W     = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]      LAST_CODE = 3'(NUM_CODES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t           r_state;
    logic [2:0]       r_code;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_sel;
    logic             r_en;
    logic             r_busy;
    logic             r_done;
    logic [7:0]       r_result;

    // -----------------------------------------------------------------------
    // Next-state / next-value wires
    // -----------------------------------------------------------------------
    state_t           w_state_nxt;
    logic [2:0]       w_code_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_sel_nxt;
    logic             w_en_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic [7:0]       w_result_nxt;
    logic             w_abort;
    logic             w_settled;
    logic             w_last_code;

`ifdef SCAN_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_settled   = (r_cnt == CNT_LAST);
    assign w_last_code = (r_code == LAST_CODE);

    // State register: asynchronous reset returns the sequencer to IDLE.
    // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> SETTLE -> SAMPLE -> (SETTLE | DONE) -> IDLE.
    // NOTE: every combinational output gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_settled) begin
                    w_state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last_code) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_DONE: begin
                // start in the DONE cycle is deliberately dropped.
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output / datapath logic: next values for code, counter, result and the
    // registered decoder-facing outputs.
    always_comb begin
        w_code_nxt   = r_code;
        w_cnt_nxt    = r_cnt;
        w_result_nxt = r_result;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_code_nxt   = 3'd0;
                    w_cnt_nxt    = '0;
                    w_result_nxt = 8'h00;
                end
            end
            S_SETTLE: begin
                if (w_abort) begin
                    w_code_nxt   = 3'd0;
                    w_cnt_nxt    = '0;
                    w_result_nxt = 8'h00;
                end else if (w_settled) begin
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_SAMPLE: begin
                if (w_abort) begin
                    w_code_nxt   = 3'd0;
                    w_cnt_nxt    = '0;
                    w_result_nxt = 8'h00;
                end else begin
                    w_result_nxt[r_code] = f;
                    // Code stops at the last value; it never wraps mid-scan.
                    if (!w_last_code) begin
                        w_code_nxt = r_code + 3'd1;
                    end
                end
            end
            S_DONE: begin
                // Result is kept for the collector until the next start.
                w_code_nxt = 3'd0;
                w_cnt_nxt  = '0;
            end
            default: begin
                w_code_nxt   = 3'd0;
                w_cnt_nxt    = '0;
                w_result_nxt = 8'h00;
            end
        endcase

        // Decoder-facing outputs follow the state being entered, so they are
        // valid from the first cycle of that state.
        w_en_nxt   = (w_state_nxt == S_SETTLE) || (w_state_nxt == S_SAMPLE);
        w_busy_nxt = w_en_nxt;
        w_done_nxt = (w_state_nxt == S_DONE);
        w_sel_nxt  = w_en_nxt ? w_code_nxt : 3'd000;
    end

    // Datapath and output registers: all cleared asynchronously, so a reset
    // mid-scan discards the partial result and suppresses done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code   <= 3'd0;
            r_cnt    <= '0;
            r_sel    <= 3'd0;
            r_en     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 8'h00;
        end else begin
            r_code   <= w_code_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sel    <= w_sel_nxt;
            r_en     <= w_en_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_result <= w_result_nxt;
        end
    end

    // w0 is the select MSB.
    assign w0     = r_sel[2];
    assign w1     = r_sel[1];
    assign w2     = r_sel[0];
    assign en     = r_en;
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule
